stopwatch_time_core: RTL and testbench

//   Consumer end of the button step-pulse interface. Takes single-cycle run/stop
//   and clear step pulses from the button pulse generators and runs the stopwatch

---
 rtl/stopwatch_defs.sv | 21 ++
 rtl/wrap_counter.sv | 40 ++++
 rtl/stopwatch_time_core.sv | 118 +++++++++++
 tb/tb_stopwatch_time_core.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_defs.sv
// Shared definitions for the stopwatch time core: FSM encodings, field widths
// and the wrap limit of each time field.
package stopwatch_defs;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } sw_state_t;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam int MSEC_MAX = 99;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; carry flags the increment
// that wraps MAX back to zero so stages can be chained.
module wrap_counter #(
  parameter int WIDTH = 7,
  parameter int MAX   = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = (count_q == MAX_V) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign carry = inc && (count_q == MAX_V);

endmodule

// File: rtl/stopwatch_time_core.sv
// Stopwatch control FSM, centisecond time base and cascaded cs/sec/min/hour
// counters, driven by single-cycle run/stop and clear pulses.
module stopwatch_time_core
  import stopwatch_defs::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_stop_pulse,
  input  logic              clear_pulse,
  output logic [MSEC_W-1:0] msec,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              running
);

  localparam int DIV_RATIO = CLK_HZ / TICK_HZ;
  localparam int DIV_W     = $clog2(DIV_RATIO);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV_RATIO - 1);

  sw_state_t        state_q, state_d;
  logic             running_q, running_d;
  logic [DIV_W-1:0] divider_q, divider_d;
  logic             tick;
  logic             clr_counters;
  logic             msec_carry, sec_carry, min_carry;
  logic             unused_hour_carry;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        // run/stop has priority; a simultaneous clear is dropped
        if (run_stop_pulse) begin
          state_d = ST_RUN;
        end else if (clear_pulse) begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN: begin
        if (run_stop_pulse) begin
          state_d = ST_STOP;
        end
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
    running_d = (state_d == ST_RUN);
  end

  assign tick         = (state_q == ST_RUN) && (divider_q == DIV_MAX);
  assign clr_counters = (state_q == ST_CLEAR);

  // The divider only holds in STOP, so a paused partial tick survives resume.
  always_comb begin
    divider_d = divider_q;
    if (state_q == ST_CLEAR) begin
      divider_d = '0;
    end else if (state_q == ST_RUN) begin
      divider_d = tick ? '0 : divider_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STOP;
      running_q <= 1'b0;
      divider_q <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      divider_q <= divider_d;
    end
  end

  wrap_counter #(.WIDTH(MSEC_W), .MAX(MSEC_MAX)) u_msec (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_counters),
    .inc   (tick),
    .count (msec),
    .carry (msec_carry)
  );

  wrap_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_counters),
    .inc   (msec_carry),
    .count (sec),
    .carry (sec_carry)
  );

  wrap_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_counters),
    .inc   (sec_carry),
    .count (min),
    .carry (min_carry)
  );

  // Hours wrap silently; there is no overflow indication.
  wrap_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_counters),
    .inc   (min_carry),
    .count (hour),
    .carry (unused_hour_carry)
  );

  assign running = running_q;

endmodule

// File: tb/tb_stopwatch_time_core.sv
// Directed bench for stopwatch_time_core at 10 clocks per tick; inputs change
// and outputs are sampled on the falling edge.
module tb_stopwatch_time_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_stop_pulse = 1'b0;
  logic       clear_pulse = 1'b0;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       running;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  stopwatch_time_core #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .run_stop_pulse (run_stop_pulse),
    .clear_pulse    (clear_pulse),
    .msec           (msec),
    .sec            (sec),
    .min            (min),
    .hour           (hour),
    .running        (running)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one-cycle pulses from a falling edge; returns one falling edge later.
  task automatic pulse(input logic rs, input logic cl);
    run_stop_pulse = rs;
    clear_pulse    = cl;
    @(negedge clk);
    run_stop_pulse = 1'b0;
    clear_pulse    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step(2);
    checks++;
    if ({hour, min, sec, msec, running} !== 25'd0) begin
      fails++;
      $display("FAIL reset_held: got %0d:%0d:%0d:%0d run=%0b, want 0:0:0:0 run=0", hour, min, sec, msec, running);
    end
    rst = 1'b0;
    step(50);
    checks++;
    if ({hour, min, sec, msec, running} !== 25'd0) begin
      fails++;
      $display("FAIL reset_idle50: got %0d:%0d:%0d:%0d run=%0b, want 0:0:0:0 run=0", hour, min, sec, msec, running);
    end
    $display("test_reset done");
  endtask

  task automatic test_run();
    pulse(1'b1, 1'b0);
    checks++;
    if (running !== 1'b1 || msec !== 7'd0) begin
      fails++;
      $display("FAIL run_start: got run=%0b msec=%0d, want run=1 msec=0", running, msec);
    end
    step(100);
    checks++;
    if ({hour, min, sec, msec} !== {5'd0, 6'd0, 6'd0, 7'd10} || running !== 1'b1) begin
      fails++;
      $display("FAIL run_100: got %0d:%0d:%0d:%0d run=%0b, want 0:0:0:10 run=1", hour, min, sec, msec, running);
    end
    step(900);
    checks++;
    if ({hour, min, sec, msec} !== {5'd0, 6'd0, 6'd1, 7'd0}) begin
      fails++;
      $display("FAIL sec_carry: got %0d:%0d:%0d:%0d, want 0:0:1:0", hour, min, sec, msec);
    end
    $display("test_run done");
  endtask

  task automatic test_pause_resume();
    do_reset();
    pulse(1'b1, 1'b0);
    step(24);
    pulse(1'b1, 1'b0);
    step(30);
    checks++;
    if (msec !== 7'd2 || running !== 1'b0) begin
      fails++;
      $display("FAIL paused: got msec=%0d run=%0b, want msec=2 run=0", msec, running);
    end
    pulse(1'b1, 1'b0);
    step(4);
    checks++;
    if (msec !== 7'd2 || running !== 1'b1) begin
      fails++;
      $display("FAIL resume_4clk: got msec=%0d run=%0b, want msec=2 run=1", msec, running);
    end
    step(1);
    checks++;
    if (msec !== 7'd3) begin
      fails++;
      $display("FAIL resume_5clk: got msec=%0d, want 3", msec);
    end
    $display("test_pause_resume done");
  endtask

  task automatic test_stop_on_tick();
    do_reset();
    pulse(1'b1, 1'b0);
    step(9);
    pulse(1'b1, 1'b0);
    checks++;
    if (msec !== 7'd1 || running !== 1'b0) begin
      fails++;
      $display("FAIL stop_on_tick: got msec=%0d run=%0b, want msec=1 run=0", msec, running);
    end
    $display("test_stop_on_tick done");
  endtask

  task automatic test_clear();
    do_reset();
    pulse(1'b1, 1'b0);
    step(374);
    pulse(1'b1, 1'b0);
    checks++;
    if (msec !== 7'd37 || running !== 1'b0) begin
      fails++;
      $display("FAIL clear_setup: got msec=%0d run=%0b, want msec=37 run=0", msec, running);
    end
    pulse(1'b0, 1'b1);
    checks++;
    if (msec !== 7'd37 || running !== 1'b0) begin
      fails++;
      $display("FAIL clear_in_state: got msec=%0d run=%0b, want msec=37 run=0", msec, running);
    end
    step(1);
    checks++;
    if ({hour, min, sec, msec, running} !== 25'd0) begin
      fails++;
      $display("FAIL clear_done: got %0d:%0d:%0d:%0d run=%0b, want 0:0:0:0 run=0", hour, min, sec, msec, running);
    end
    // A cleared divider means the first tick needs a full 10 running edges.
    pulse(1'b1, 1'b0);
    step(9);
    checks++;
    if (msec !== 7'd0) begin
      fails++;
      $display("FAIL clear_div_9: got msec=%0d, want 0", msec);
    end
    step(1);
    checks++;
    if (msec !== 7'd1) begin
      fails++;
      $display("FAIL clear_div_10: got msec=%0d, want 1", msec);
    end
    pulse(1'b0, 1'b1);
    step(1);
    checks++;
    if (msec !== 7'd1 || running !== 1'b1) begin
      fails++;
      $display("FAIL clear_in_run: got msec=%0d run=%0b, want msec=1 run=1", msec, running);
    end
    $display("test_clear done");
  endtask

  task automatic test_both_pulses();
    pulse(1'b1, 1'b0);
    checks++;
    if (running !== 1'b0 || msec !== 7'd1) begin
      fails++;
      $display("FAIL both_setup: got run=%0b msec=%0d, want run=0 msec=1", running, msec);
    end
    pulse(1'b1, 1'b1);
    checks++;
    if (running !== 1'b1 || msec !== 7'd1) begin
      fails++;
      $display("FAIL both_pulses: got run=%0b msec=%0d, want run=1 msec=1", running, msec);
    end
    step(2);
    checks++;
    if (running !== 1'b1 || msec !== 7'd1) begin
      fails++;
      $display("FAIL both_after: got run=%0b msec=%0d, want run=1 msec=1", running, msec);
    end
    $display("test_both_pulses done");
  endtask

  task automatic test_rollover_and_async_reset();
    @(negedge clk);
    force dut.u_msec.count_q = 7'd99;
    force dut.u_sec.count_q  = 6'd59;
    force dut.u_min.count_q  = 6'd59;
    force dut.u_hour.count_q = 5'd23;
    force dut.divider_q      = 4'd9;
    #1;
    release dut.u_msec.count_q;
    release dut.u_sec.count_q;
    release dut.u_min.count_q;
    release dut.u_hour.count_q;
    release dut.divider_q;
    #1;
    checks++;
    if ({hour, min, sec, msec} !== {5'd23, 6'd59, 6'd59, 7'd99}) begin
      fails++;
      $display("FAIL deposit: got %0d:%0d:%0d:%0d, want 23:59:59:99", hour, min, sec, msec);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({hour, min, sec, msec} !== 24'd0 || running !== 1'b1) begin
      fails++;
      $display("FAIL full_rollover: got %0d:%0d:%0d:%0d run=%0b, want 0:0:0:0 run=1", hour, min, sec, msec, running);
    end
    @(negedge clk);
    step(10);
    checks++;
    if (msec !== 7'd1) begin
      fails++;
      $display("FAIL after_rollover: got msec=%0d, want 1", msec);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({hour, min, sec, msec, running} !== 25'd0) begin
      fails++;
      $display("FAIL async_reset: got %0d:%0d:%0d:%0d run=%0b, want 0:0:0:0 run=0", hour, min, sec, msec, running);
    end
    @(negedge clk);
    rst = 1'b0;
    step(20);
    checks++;
    if ({hour, min, sec, msec, running} !== 25'd0) begin
      fails++;
      $display("FAIL post_reset_idle: got %0d:%0d:%0d:%0d run=%0b, want 0:0:0:0 run=0", hour, min, sec, msec, running);
    end
    $display("test_rollover_and_async_reset done");
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause_resume();
    test_stop_on_tick();
    test_clear();
    test_both_pulses();
    test_rollover_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
